// File: rtl/ssd_scan_decoder.sv
// rtl/ssd_scan_decoder.sv - decodes a scanned 7-segment bus back to hex digits for loopback checking
// Optional SSD_DECODE_STATS_EN adds frame_cnt/err_cnt statistics outputs.
module ssd_scan_decoder #(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 100000,
  parameter int TW          = 17
) (
  input  logic        CLK_ulong,
  input  logic        reset,
  input  logic [10:0] SSD,
  output logic [15:0] digits,
  output logic [3:0]  dig_valid,
  output logic [3:0]  dig_blank,
  output logic        frame_done,
  output logic        glyph_err,
`ifdef SSD_DECODE_STATS_EN
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt,
`endif
  output logic        scan_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic [10:0]   ssd_m, s_ssd;
  logic [3:0]    an;
  logic [6:0]    seg;
  logic          strobe;
  logic [1:0]    idx;
  logic [1:0]    lat_idx;
  logic [6:0]    lat_seg;
  logic [7:0]    settle_cnt;
  logic [8:0]    cnt_inc;
  logic          cnt_hit;
  logic          same;
  logic          new_flag;
  logic [TW-1:0] tcnt;
  logic          to_hit;
  logic [3:0]    frame_mask;
  logic          dec_ok;
  logic [3:0]    dec_val;
  logic          latch, inc, capture, new_anode;

  always_ff @(posedge CLK_ulong or negedge reset) begin
    if (!reset) begin
      ssd_m <= 11'h7FF;
      s_ssd <= 11'h7FF;
    end else begin
      ssd_m <= SSD;
      s_ssd <= ssd_m;
    end
  end

  assign an  = s_ssd[10:7];
  assign seg = s_ssd[6:0];

  // Only a single low anode is a usable strobe; idle and multi-low both fall through
  always_comb begin
    strobe = 1'b1;
    idx    = 2'd0;
    case (an)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: strobe = 1'b0;
    endcase
  end

  assign same    = strobe && (idx == lat_idx) && (seg == lat_seg);
  assign cnt_inc = {1'b0, settle_cnt} + 9'd1;
  assign cnt_hit = cnt_inc >= 9'(SETTLE_CYC);

  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'h0;
    case (lat_seg)
      7'h01: dec_val = 4'h0;
      7'h4F: dec_val = 4'h1;
      7'h12: dec_val = 4'h2;
      7'h06: dec_val = 4'h3;
      7'h4C: dec_val = 4'h4;
      7'h24: dec_val = 4'h5;
      7'h20: dec_val = 4'h6;
      7'h0F: dec_val = 4'h7;
      7'h00: dec_val = 4'h8;
      7'h04: dec_val = 4'h9;
      7'h08: dec_val = 4'hA;
      7'h60: dec_val = 4'hB;
      7'h31: dec_val = 4'hC;
      7'h42: dec_val = 4'hD;
      7'h30: dec_val = 4'hE;
      7'h38: dec_val = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  always_ff @(posedge CLK_ulong or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (strobe) state_d = S_SETTLE;
      S_SETTLE: begin
        if (!strobe)              state_d = S_IDLE;
        else if (same && cnt_hit) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!strobe)    state_d = S_IDLE;
        else if (!same) state_d = S_SETTLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    latch   = 1'b0;
    inc     = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE:   latch = strobe;
      S_SETTLE: begin
        if (strobe) begin
          if (!same)        latch   = 1'b1;
          else if (cnt_hit) capture = 1'b1;
          else              inc     = 1'b1;
        end
      end
      S_HOLD:   latch = strobe && !same;
      default:  latch = 1'b0;
    endcase
    new_anode = latch && (idx != lat_idx);
  end

  assign to_hit = !new_anode && (tcnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK_ulong or negedge reset) begin
    if (!reset) begin
      lat_idx      <= 2'd0;
      lat_seg      <= 7'h7F;
      settle_cnt   <= 8'd0;
      new_flag     <= 1'b0;
      tcnt         <= '0;
      frame_mask   <= 4'h0;
      digits       <= 16'h0000;
      dig_valid    <= 4'h0;
      dig_blank    <= 4'h0;
      frame_done   <= 1'b0;
      glyph_err    <= 1'b0;
      scan_timeout <= 1'b0;
    end else begin
      glyph_err  <= 1'b0;
      frame_done <= 1'b0;

      if (latch) begin
        lat_idx    <= idx;
        lat_seg    <= seg;
        settle_cnt <= 8'd1;
        if (new_anode) new_flag <= 1'b1;
      end else if (inc) begin
        settle_cnt <= settle_cnt + 8'd1;
      end

      if (new_anode)                     tcnt <= '0;
      else if (tcnt != TW'(TIMEOUT_CYC)) tcnt <= tcnt + TW'(1);

      if (frame_mask == 4'hF) begin
        frame_done <= 1'b1;
        frame_mask <= 4'h0;
      end

      if (capture) begin
        new_flag            <= 1'b0;
        frame_mask[lat_idx] <= 1'b1;
        if (new_flag) scan_timeout <= 1'b0;
        if (dec_ok) begin
          digits[{lat_idx, 2'b00} +: 4] <= dec_val;
          dig_valid[lat_idx]            <= 1'b1;
          dig_blank[lat_idx]            <= 1'b0;
        end else if (lat_seg == 7'h7F) begin
          dig_valid[lat_idx] <= 1'b0;
          dig_blank[lat_idx] <= 1'b1;
        end else begin
          glyph_err          <= 1'b1;
          dig_valid[lat_idx] <= 1'b0;
          dig_blank[lat_idx] <= 1'b0;
        end
      end

      // Losing the scan invalidates everything gathered so far
      if (to_hit) begin
        scan_timeout <= 1'b1;
        dig_valid    <= 4'h0;
        frame_mask   <= 4'h0;
      end
    end
  end

`ifdef SSD_DECODE_STATS_EN
  logic       glitch, glitch_q;
  logic [8:0] err_sum;

  assign glitch  = !strobe && (an != 4'hF);
  assign err_sum = {1'b0, err_cnt} + 9'(glyph_err) + 9'(glitch && !glitch_q);

  always_ff @(posedge CLK_ulong or negedge reset) begin
    if (!reset) begin
      glitch_q  <= 1'b0;
      frame_cnt <= 16'h0000;
      err_cnt   <= 8'h00;
    end else begin
      glitch_q <= glitch;
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
      err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end
`endif

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// tb/tb_ssd_scan_decoder.sv - directed self-checking bench for ssd_scan_decoder
module tb_ssd_scan_decoder;

  localparam logic [3:0] AN0 = 4'b1110;
  localparam logic [3:0] AN1 = 4'b1101;
  localparam logic [3:0] AN2 = 4'b1011;
  localparam logic [3:0] AN3 = 4'b0111;
  localparam logic [3:0] ANX = 4'b1111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] ssd = 11'h7FF;
  logic [15:0] digits;
  logic [3:0]  dig_valid, dig_blank;
  logic        frame_done, glyph_err, scan_timeout;
`ifdef SSD_DECODE_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
`endif

  int total = 0, passed = 0, failed = 0;
  int fd_cnt = 0, ge_cnt = 0, fd0, ge0;

  ssd_scan_decoder #(.SETTLE_CYC(4), .TIMEOUT_CYC(50), .TW(17)) dut (
    .CLK_ulong    (clk),
    .reset        (rst_n),
    .SSD          (ssd),
    .digits       (digits),
    .dig_valid    (dig_valid),
    .dig_blank    (dig_blank),
    .frame_done   (frame_done),
    .glyph_err    (glyph_err),
`ifdef SSD_DECODE_STATS_EN
    .frame_cnt    (frame_cnt),
    .err_cnt      (err_cnt),
`endif
    .scan_timeout (scan_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (glyph_err)  ge_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg);
    ssd = {an, seg};
  endtask

  task automatic scan(input logic [3:0] an, input logic [6:0] seg);
    drive(an, seg);
    tick(8);
  endtask

  initial begin
    tick(3);
    check("rst_digits", digits, 32'h0);
    check("rst_valid", dig_valid, 32'h0);
    check("rst_blank", dig_blank, 32'h0);
    check("rst_frame_done", frame_done, 32'h0);
    check("rst_glyph_err", glyph_err, 32'h0);
    check("rst_timeout", scan_timeout, 32'h0);
    rst_n = 1'b1;
    tick(2);

    fd0 = fd_cnt; ge0 = ge_cnt;
    scan(AN0, 7'h4F);
    scan(AN1, 7'h12);
    scan(AN2, 7'h06);
    drive(AN3, 7'h4C);
    tick(6);
    check("scan_digits", digits, 32'h4321);
    check("scan_valid", dig_valid, 32'hF);
    check("frame_done_early", frame_done, 32'h0);
    tick(1);
    check("frame_done_pulse", frame_done, 32'h1);
    tick(1);
    check("frame_done_end", frame_done, 32'h0);
    check("frame_pulses", 32'(fd_cnt - fd0), 32'h1);
    check("scan_no_glyph_err", 32'(ge_cnt - ge0), 32'h0);

    drive(AN1, 7'h7F);
    tick(10);
    check("blank_flag", dig_blank, 32'h2);
    check("blank_valid", dig_valid, 32'hD);
    check("blank_digits", digits, 32'h4321);

    ge0 = ge_cnt;
    drive(AN2, 7'h55);
    tick(6);
    check("glyph_err_pulse", glyph_err, 32'h1);
    drive(ANX, 7'h7F);
    tick(3);
    check("glyph_err_count", 32'(ge_cnt - ge0), 32'h1);
    check("glyph_valid", dig_valid, 32'h9);
    check("glyph_blank", dig_blank, 32'h2);
    check("glyph_digits", digits, 32'h4321);

    ge0 = ge_cnt;
    drive(4'b1100, 7'h4C);
    tick(8);
    drive(ANX, 7'h7F);
    tick(3);
    check("glitch_digits", digits, 32'h4321);
    check("glitch_valid", dig_valid, 32'h9);
    check("glitch_no_err", 32'(ge_cnt - ge0), 32'h0);
`ifdef SSD_DECODE_STATS_EN
    check("err_cnt", err_cnt, 32'h2);
    check("frame_cnt", frame_cnt, 32'h1);
`endif

    drive(AN0, 7'h01);
    tick(52);
    check("timeout_before", scan_timeout, 32'h0);
    check("frozen_valid", dig_valid, 32'h9);
    check("frozen_digits", digits, 32'h4320);
    tick(1);
    check("timeout_set", scan_timeout, 32'h1);
    check("timeout_valid", dig_valid, 32'h0);

    fd0 = fd_cnt;
    drive(AN1, 7'h12);
    tick(5);
    check("timeout_hold", scan_timeout, 32'h1);
    tick(1);
    check("timeout_clear", scan_timeout, 32'h0);
    tick(2);
    scan(AN2, 7'h06);
    scan(AN3, 7'h4C);
    scan(AN0, 7'h4F);
    check("resume_frame", 32'(fd_cnt - fd0), 32'h1);
    check("resume_digits", digits, 32'h4321);
    check("resume_valid", dig_valid, 32'hF);

    drive(AN1, 7'h12);
    tick(4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_digits", digits, 32'h0);
    check("arst_valid", dig_valid, 32'h0);
    check("arst_blank", dig_blank, 32'h0);
    check("arst_timeout", scan_timeout, 32'h0);
    tick(2);
    drive(ANX, 7'h7F);
    rst_n = 1'b1;
    tick(3);
    scan(AN0, 7'h4F);
    scan(AN1, 7'h12);
    scan(AN2, 7'h06);
    scan(AN3, 7'h4C);
    check("post_rst_digits", digits, 32'h4321);
    check("post_rst_valid", dig_valid, 32'hF);
`ifdef SSD_DECODE_STATS_EN
    check("post_rst_frame_cnt", frame_cnt, 32'h1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ssd_scan_decoder.md
Name: ssd_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed 7-segment driver.
- Samples the 11-bit scanned SSD bus, locks onto each anode strobe, and decodes the segment glyph back to a 4-bit hex value per digit.
- Reports a per-digit valid flag, a frame-complete pulse, and glitch, glyph and timeout errors.
- Sits beside the alarm FSM and display driver as an on-chip loopback checker, so the bench and board can confirm that estado/sensores reached the display.

Parameters:
- SETTLE_CYC, 4: consecutive identical samples required before a digit is captured (range 1..255).
- TIMEOUT_CYC, 100000: cycles without a valid anode change before scan_timeout asserts.
- TW, 17: width of the timeout counter; must satisfy 2^TW > TIMEOUT_CYC.

Ports:
- CLK_ulong  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- SSD  in  11  SSD[10:7] = anodes AN3..AN0, active-low, one-hot when driven; SSD[6:0] = segments {a,b,c,d,e,f,g}, active-low.
- digits  out  16  decoded hex values, digit n in bits [4n+3:4n].
- dig_valid  out  4  bit n = digit n holds a legal glyph from the latest capture.
- dig_blank  out  4  bit n = digit n captured as all-off (7'h7F).
- frame_done  out  1  one-cycle pulse when all 4 digits have been captured since the last pulse.
- glyph_err  out  1  one-cycle pulse when a settled pattern is not in the table.
- scan_timeout  out  1  level; scan activity lost.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, digits=16'h0000, FSM in IDLE, counters cleared, frame mask cleared.
- Input stage: SSD passes through a 2-flop synchroniser. All decisions use the second stage (s_ssd). This adds a 2-cycle input latency.
- Anode classification:
  - Exactly one anode low: an active strobe, with index n.
  - All anodes high: idle.
  - More than one anode low: a glitch. Treat it as idle and restart settle.
- Decode table (segments hex, giving value):
  - 01=0, 4F=1, 12=2, 06=3, 4C=4, 24=5, 20=6, 0F=7, 00=8, 04=9
  - 08=A, 60=b, 31=C, 42=d, 30=E, 38=F
  - 7F = blank. Set dig_blank[n], clear dig_valid[n], leave digits[n] unchanged.
  - Any other pattern: pulse glyph_err, clear dig_valid[n] and dig_blank[n].
- FSM states:
  - IDLE:
    - Active strobe -> SETTLE, with settle_cnt=1 and the pattern latched.
  - SETTLE:
    - Sample equal to the latched pattern: settle_cnt++.
    - Sample differs but is still an active strobe: relatch and set settle_cnt=1.
    - Idle or glitch: -> IDLE.
    - settle_cnt reaches SETTLE_CYC: capture -> HOLD.
    - Capture register updates occur in the cycle the state enters HOLD.
  - HOLD:
    - Same anode and segments: stay.
    - Different active anode: -> SETTLE.
    - Idle: -> IDLE.
    - Same anode with changed segments: -> SETTLE (re-capture).
- Frame tracking:
  - frame_mask[n] is set on each capture of digit n, whatever the glyph result.
  - When the mask reaches 4'hF, frame_done pulses for 1 cycle in the cycle after that capture, and the mask clears.
  - Re-capturing an already-set digit has no effect on the mask.
- Timeout:
  - The counter resets on every transition into SETTLE caused by a new anode index.
  - Otherwise it increments and saturates at TIMEOUT_CYC.
  - At TIMEOUT_CYC: scan_timeout=1, dig_valid=0, frame_mask cleared.
  - scan_timeout clears on the next new-anode capture.
- Simultaneous events: if a glyph_err and frame_done would fall in the same cycle, both pulse.
- Reset mid-operation: everything reverts immediately to the reset values. No partial capture survives.

Optional Feature:
SSD_DECODE_STATS_EN
- Defined:
  - Adds outputs frame_cnt[15:0] and err_cnt[7:0]. Both reset to 0.
  - frame_cnt increments on each frame_done and wraps 16'hFFFF -> 0.
  - err_cnt increments on each glyph_err or glitch detection and saturates at 8'hFF.
- Undefined: the ports and logic are absent. The rest of the behaviour is identical.

Test Plan:
- Scan AN0..AN3 with glyphs 4F, 12, 06, 4C, each held 8 cycles (SETTLE_CYC=4) -> digits=16'h4321, dig_valid=4'hF, exactly one frame_done pulse about 2 cycles after the AN3 capture.
- Hold AN1 with segments 7F for 10 cycles -> dig_blank[1]=1, dig_valid[1]=0, digits[7:4] unchanged.
- Drive AN2 with segments 7'h55 for 6 cycles -> exactly one glyph_err pulse, dig_valid[2]=0.
- Drive anodes 4'b1100 (two low) with a valid glyph -> no capture, FSM in IDLE, and err_cnt+1 when SSD_DECODE_STATS_EN is defined.
- Freeze the bus on AN0 with TIMEOUT_CYC=50 -> scan_timeout=1 at cycle 50 after the last new-anode entry into SETTLE, dig_valid=0. Resuming the scan clears it on the next capture.
- Pull reset low mid-SETTLE with digits=16'h4321 -> all outputs 0 asynchronously. After release, a full scan reproduces 16'h4321.
